// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef logic [4:0] reg_addr_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam int LAT_CNT_W = 3;

    // EX/MEM result is younger than MEM/WB data, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic      ex_we,
        input reg_addr_t ex_rd,
        input logic      wb_we,
        input reg_addr_t wb_rd,
        input reg_addr_t src
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (ex_we && (ex_rd != '0) && (ex_rd == src)) begin
            sel = FWD_MEM;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX-stage forwarding select generation for both ALU operands.
module fwd_unit
    import hazard_pkg::*;
(
    input  logic       exmem_reg_write,
    input  reg_addr_t  exmem_write_reg,
    input  logic       memwb_reg_write,
    input  reg_addr_t  memwb_write_reg,
    input  reg_addr_t  idex_src_reg,
    input  reg_addr_t  idex_tar_reg,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    always_comb begin
        fwd_a = fwd_sel(exmem_reg_write, exmem_write_reg,
                        memwb_reg_write, memwb_write_reg, idex_src_reg);
        fwd_b = fwd_sel(exmem_reg_write, exmem_write_reg,
                        memwb_reg_write, memwb_write_reg, idex_tar_reg);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall / branch flush sequencing, forwarding selects and
// saturating stall/flush statistics for the 5-stage pipeline.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | normal issue; a load-use hazard stalls this cycle
//   STALL | remaining stall cycles of a multi-cycle load-use (cnt left)
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_id_src_reg,
    input  logic [4:0]       i_id_tar_reg,
    input  logic             i_id_uses_rt,
    input  logic             i_idex_mem_read,
    input  logic [4:0]       i_idex_src_reg,
    input  logic [4:0]       i_idex_tar_reg,
    input  logic             i_exmem_reg_write,
    input  logic [4:0]       i_exmem_write_reg,
    input  logic             i_memwb_reg_write,
    input  logic [4:0]       i_memwb_write_reg,
    input  logic             i_branch_taken,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_if_flush,
    output logic             o_idex_bubble,
    output logic             o_exmem_bubble,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    // The detection cycle is stall cycle 1, so STALL covers LOAD_LAT-1 more.
    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

    state_t               state_q, state_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 lu_hazard;
    logic                 flush;
    logic                 stall;
    logic [1:0]           fwd_a_raw, fwd_b_raw;
    logic [CNT_W-1:0]     stall_cnt_q, flush_cnt_q;

    always_comb begin
        lu_hazard = i_idex_mem_read && (i_idex_tar_reg != '0) &&
                    ((i_idex_tar_reg == i_id_src_reg) ||
                     (i_id_uses_rt && (i_idex_tar_reg == i_id_tar_reg)));
        flush     = i_branch_taken;
        stall     = !flush && ((state_q == STALL) || lu_hazard);
    end

    fwd_unit u_fwd (
        .exmem_reg_write (i_exmem_reg_write),
        .exmem_write_reg (i_exmem_write_reg),
        .memwb_reg_write (i_memwb_reg_write),
        .memwb_write_reg (i_memwb_write_reg),
        .idex_src_reg    (i_idex_src_reg),
        .idex_tar_reg    (i_idex_tar_reg),
        .fwd_a           (fwd_a_raw),
        .fwd_b           (fwd_b_raw)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A taken branch aborts any pending stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = RUN;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            if (lu_hazard && (LOAD_LAT > 1)) begin
                state_d = STALL;
                cnt_d   = LAT_INIT;
            end
        end else begin
            if (cnt_q == LAT_CNT_W'(1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - LAT_CNT_W'(1);
            end
        end
    end

    // Outputs are held inactive for the whole reset window, not just at the edge.
    always_comb begin
        o_pc_write     = 1'b0;
        o_ifid_write   = 1'b0;
        o_if_flush     = 1'b0;
        o_idex_bubble  = 1'b0;
        o_exmem_bubble = 1'b0;
        o_fwd_a        = FWD_RF;
        o_fwd_b        = FWD_RF;
        if (i_rst_n) begin
            o_fwd_a = fwd_a_raw;
            o_fwd_b = fwd_b_raw;
            if (flush) begin
                o_pc_write     = 1'b1;
                o_if_flush     = 1'b1;
                o_idex_bubble  = 1'b1;
                o_exmem_bubble = 1'b1;
            end else if (stall) begin
                o_idex_bubble  = 1'b1;
            end else begin
                o_pc_write     = 1'b1;
                o_ifid_write   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (flush && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: three parameterisations share stimulus,
// each phase resets all and checks one instance against hand-computed values.
module tb_hazard_ctrl;

    typedef struct {
        int          dut;
        string       name;
        logic        pc;
        logic        ifid;
        logic        fl;
        logic        ib;
        logic        eb;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_src, id_tar, idex_src, idex_tar, exmem_wr, memwb_wr;
    logic       uses_rt, mem_read, exmem_we, memwb_we, br;

    logic [2:0]  pc_v, ifid_v, fl_v, ib_v, eb_v;
    logic [1:0]  fa_v [3];
    logic [1:0]  fb_v [3];
    logic [15:0] sc0, sc1, fc0, fc1;
    logic [1:0]  sc2, fc2;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_src_reg(id_src), .i_id_tar_reg(id_tar), .i_id_uses_rt(uses_rt),
        .i_idex_mem_read(mem_read), .i_idex_src_reg(idex_src), .i_idex_tar_reg(idex_tar),
        .i_exmem_reg_write(exmem_we), .i_exmem_write_reg(exmem_wr),
        .i_memwb_reg_write(memwb_we), .i_memwb_write_reg(memwb_wr),
        .i_branch_taken(br),
        .o_pc_write(pc_v[0]), .o_ifid_write(ifid_v[0]), .o_if_flush(fl_v[0]),
        .o_idex_bubble(ib_v[0]), .o_exmem_bubble(eb_v[0]),
        .o_fwd_a(fa_v[0]), .o_fwd_b(fb_v[0]),
        .o_stall_cnt(sc0), .o_flush_cnt(fc0)
    );

    hazard_ctrl #(.LOAD_LAT(3), .CNT_W(16)) u1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_src_reg(id_src), .i_id_tar_reg(id_tar), .i_id_uses_rt(uses_rt),
        .i_idex_mem_read(mem_read), .i_idex_src_reg(idex_src), .i_idex_tar_reg(idex_tar),
        .i_exmem_reg_write(exmem_we), .i_exmem_write_reg(exmem_wr),
        .i_memwb_reg_write(memwb_we), .i_memwb_write_reg(memwb_wr),
        .i_branch_taken(br),
        .o_pc_write(pc_v[1]), .o_ifid_write(ifid_v[1]), .o_if_flush(fl_v[1]),
        .o_idex_bubble(ib_v[1]), .o_exmem_bubble(eb_v[1]),
        .o_fwd_a(fa_v[1]), .o_fwd_b(fb_v[1]),
        .o_stall_cnt(sc1), .o_flush_cnt(fc1)
    );

    hazard_ctrl #(.LOAD_LAT(1), .CNT_W(2)) u2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_src_reg(id_src), .i_id_tar_reg(id_tar), .i_id_uses_rt(uses_rt),
        .i_idex_mem_read(mem_read), .i_idex_src_reg(idex_src), .i_idex_tar_reg(idex_tar),
        .i_exmem_reg_write(exmem_we), .i_exmem_write_reg(exmem_wr),
        .i_memwb_reg_write(memwb_we), .i_memwb_write_reg(memwb_wr),
        .i_branch_taken(br),
        .o_pc_write(pc_v[2]), .o_ifid_write(ifid_v[2]), .o_if_flush(fl_v[2]),
        .o_idex_bubble(ib_v[2]), .o_exmem_bubble(eb_v[2]),
        .o_fwd_a(fa_v[2]), .o_fwd_b(fb_v[2]),
        .o_stall_cnt(sc2), .o_flush_cnt(fc2)
    );

    task automatic chk(input string nm, input string fld, input int d,
                       input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s.%s dut%0d got=%0h expected=%0h", nm, fld, d, act, expv);
        end
    endtask

    // Monitor: one expected entry per checked cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [15:0] sc, fc;
            e = q.pop_front();
            case (e.dut)
                0:       begin sc = sc0; fc = fc0; end
                1:       begin sc = sc1; fc = fc1; end
                default: begin sc = {14'd0, sc2}; fc = {14'd0, fc2}; end
            endcase
            chk(e.name, "pc_write",    e.dut, {15'd0, pc_v[e.dut]},   {15'd0, e.pc});
            chk(e.name, "ifid_write",  e.dut, {15'd0, ifid_v[e.dut]}, {15'd0, e.ifid});
            chk(e.name, "if_flush",    e.dut, {15'd0, fl_v[e.dut]},   {15'd0, e.fl});
            chk(e.name, "idex_bubble", e.dut, {15'd0, ib_v[e.dut]},   {15'd0, e.ib});
            chk(e.name, "exmem_bubble",e.dut, {15'd0, eb_v[e.dut]},   {15'd0, e.eb});
            chk(e.name, "fwd_a",       e.dut, {14'd0, fa_v[e.dut]},   {14'd0, e.fa});
            chk(e.name, "fwd_b",       e.dut, {14'd0, fb_v[e.dut]},   {14'd0, e.fb});
            chk(e.name, "stall_cnt",   e.dut, sc, e.sc);
            chk(e.name, "flush_cnt",   e.dut, fc, e.fc);
        end
    end

    task automatic clr_in();
        id_src = 0; id_tar = 0; uses_rt = 0; mem_read = 0;
        idex_src = 0; idex_tar = 0; exmem_we = 0; exmem_wr = 0;
        memwb_we = 0; memwb_wr = 0; br = 0;
    endtask

    task automatic cyc(input int d, input string nm,
                       input logic pc, input logic ifid, input logic fl,
                       input logic ib, input logic eb,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic [15:0] sc, input logic [15:0] fc);
        exp_t e;
        e.dut = d; e.name = nm; e.pc = pc; e.ifid = ifid; e.fl = fl;
        e.ib = ib; e.eb = eb; e.fa = fa; e.fb = fb; e.sc = sc; e.fc = fc;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_in();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        clr_in();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // reset forces outputs even with flush, hazard and forwarding inputs active
        br = 1; mem_read = 1; idex_tar = 5; id_src = 5;
        exmem_we = 1; exmem_wr = 5; idex_src = 5;
        cyc(1, "in_reset", 0,0,0,0,0, 2'b00,2'b00, 0,0);

        // load-use on rs, LOAD_LAT=1
        do_reset();
        mem_read = 1; idex_tar = 5; id_src = 5;
        cyc(0, "lu_rs",      0,0,0,1,0, 2'b00,2'b00, 0,0);
        clr_in();
        cyc(0, "lu_rs_after",1,1,0,0,0, 2'b00,2'b00, 1,0);
        mem_read = 1; idex_tar = 5; id_tar = 5; id_src = 1; uses_rt = 0;
        cyc(0, "rt_unused",  1,1,0,0,0, 2'b00,2'b00, 1,0);
        uses_rt = 1;
        cyc(0, "rt_used",    0,0,0,1,0, 2'b00,2'b00, 1,0);
        clr_in();
        mem_read = 1; idex_tar = 0; id_src = 0;
        cyc(0, "r0_load",    1,1,0,0,0, 2'b00,2'b00, 2,0);
        clr_in();
        cyc(0, "idle",       1,1,0,0,0, 2'b00,2'b00, 2,0);

        // LOAD_LAT=3 stall runs exactly three cycles
        do_reset();
        mem_read = 1; idex_tar = 7; id_src = 7;
        cyc(1, "lat3_c1",    0,0,0,1,0, 2'b00,2'b00, 0,0);
        clr_in();
        cyc(1, "lat3_c2",    0,0,0,1,0, 2'b00,2'b00, 1,0);
        cyc(1, "lat3_c3",    0,0,0,1,0, 2'b00,2'b00, 2,0);
        cyc(1, "lat3_done",  1,1,0,0,0, 2'b00,2'b00, 3,0);

        // taken branch on stall cycle 2 aborts the stall
        do_reset();
        mem_read = 1; idex_tar = 7; id_src = 7;
        cyc(1, "abort_c1",   0,0,0,1,0, 2'b00,2'b00, 0,0);
        clr_in();
        br = 1;
        cyc(1, "abort_flush",1,0,1,1,1, 2'b00,2'b00, 1,0);
        clr_in();
        cyc(1, "abort_next", 1,1,0,0,0, 2'b00,2'b00, 1,1);
        cyc(1, "abort_next2",1,1,0,0,0, 2'b00,2'b00, 1,1);

        // forwarding priority and r0 exclusion
        do_reset();
        exmem_we = 1; exmem_wr = 3; memwb_we = 1; memwb_wr = 3; idex_src = 3;
        cyc(0, "fwd_ex",     1,1,0,0,0, 2'b10,2'b00, 0,0);
        exmem_we = 0;
        cyc(0, "fwd_wb",     1,1,0,0,0, 2'b01,2'b00, 0,0);
        exmem_we = 1; exmem_wr = 0;
        cyc(0, "fwd_ex_r0",  1,1,0,0,0, 2'b01,2'b00, 0,0);
        exmem_we = 0; memwb_we = 0; exmem_wr = 3;
        cyc(0, "fwd_none",   1,1,0,0,0, 2'b00,2'b00, 0,0);
        exmem_we = 1; exmem_wr = 7; memwb_we = 1; memwb_wr = 3; idex_tar = 7;
        cyc(0, "fwd_split",  1,1,0,0,0, 2'b01,2'b10, 0,0);

        // saturation with a 2-bit counter under continuous stall
        do_reset();
        mem_read = 1; idex_tar = 9; id_src = 9;
        cyc(2, "sat_0",      0,0,0,1,0, 2'b00,2'b00, 0,0);
        cyc(2, "sat_1",      0,0,0,1,0, 2'b00,2'b00, 1,0);
        cyc(2, "sat_2",      0,0,0,1,0, 2'b00,2'b00, 2,0);
        cyc(2, "sat_3",      0,0,0,1,0, 2'b00,2'b00, 3,0);
        cyc(2, "sat_hold",   0,0,0,1,0, 2'b00,2'b00, 3,0);

        // reset pulse in STALL
        do_reset();
        mem_read = 1; idex_tar = 7; id_src = 7;
        cyc(1, "rs_c1",      0,0,0,1,0, 2'b00,2'b00, 0,0);
        clr_in();
        cyc(1, "rs_c2",      0,0,0,1,0, 2'b00,2'b00, 1,0);
        rst_n = 1'b0;
        cyc(1, "rs_forced",  0,0,0,0,0, 2'b00,2'b00, 0,0);
        rst_n = 1'b1;
        cyc(1, "rs_release", 1,1,0,0,0, 2'b00,2'b00, 0,0);
        cyc(1, "rs_release2",1,1,0,0,0, 2'b00,2'b00, 0,0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It detects load-use hazards and stalls PC and IF/ID while injecting ID/EX bubbles, and flushes wrong-path instructions when a branch resolves taken in MEM. It also generates EX-stage forwarding selects and keeps saturating stall/flush statistics counters. Outputs drive the PC enable, the IF/ID write/flush controls, and the control-zeroing muxes in front of ID/EX and EX/MEM.

Parameters:
LOAD_LAT, 1, number of stall cycles per load-use hazard (1..7); values >1 model a slow data-memory read path
CNT_W, 16, width of statistics counters

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_id_src_reg  in  5  rs of instruction in ID
i_id_tar_reg  in  5  rt of instruction in ID
i_id_uses_rt  in  1  ID instruction reads rt as a source
i_idex_mem_read  in  1  instruction in EX is a load
i_idex_src_reg  in  5  rs in EX
i_idex_tar_reg  in  5  rt in EX (load destination)
i_exmem_reg_write  in  1  MEM-stage instruction writes a register
i_exmem_write_reg  in  5  MEM-stage destination
i_memwb_reg_write  in  1  WB-stage instruction writes a register
i_memwb_write_reg  in  5  WB-stage destination
i_branch_taken  in  1  branch in MEM is taken (branch AND zero)
o_pc_write  out  1  PC update enable
o_ifid_write  out  1  IF/ID write enable
o_if_flush  out  1  IF/ID flush
o_idex_bubble  out  1  zero WB/MEM/EX controls entering ID/EX
o_exmem_bubble  out  1  zero WB/MEM controls entering EX/MEM
o_fwd_a  out  2  ALU operand A select: 00 regfile, 10 EX/MEM result, 01 MEM/WB data
o_fwd_b  out  2  ALU operand B select, same encoding
o_stall_cnt  out  CNT_W  stall cycles seen, saturating
o_flush_cnt  out  CNT_W  flush events seen, saturating

Behaviour:
- While i_rst_n=0: state=RUN, internal cnt=0, all counters 0. All control outputs are forced to pc_write=0, ifid_write=0, flush=0, bubbles=0, fwd=00.
- States: RUN, STALL. A 3-bit down-counter is used for multi-cycle stalls.
- lu_hazard = i_idex_mem_read & (i_idex_tar_reg!=0) & (i_idex_tar_reg==i_id_src_reg | (i_id_uses_rt & i_idex_tar_reg==i_id_tar_reg)).
- Control output priority each cycle: flush > stall > normal.
  - Flush (i_branch_taken=1, any state): pc_write=1, ifid_write=0, if_flush=1, idex_bubble=1, exmem_bubble=1. Next state is RUN and cnt is cleared, so a pending stall is aborted.
  - Stall (RUN & lu_hazard, or state STALL): pc_write=0, ifid_write=0, if_flush=0, idex_bubble=1, exmem_bubble=0.
  - Normal: pc_write=1, ifid_write=1, all others 0.
- RUN & lu_hazard & no flush: if LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1; otherwise stay in RUN. The detection cycle counts as stall cycle 1.
- STALL & no flush: if cnt==1, go to RUN; else cnt decrements. Total stall cycles = LOAD_LAT. lu_hazard is ignored while in STALL.
- Control outputs are combinational from state and inputs, with zero added latency.
- Forwarding (combinational, each operand):
  - Select 10 if exmem_reg_write & exmem_write_reg!=0 & match.
  - Else select 01 if memwb_reg_write & memwb_write_reg!=0 & match.
  - Else select 00.
  - fwd_a matches against i_idex_src_reg; fwd_b against i_idex_tar_reg. EX/MEM has priority over MEM/WB.
- o_stall_cnt increments on every clock edge where stall is asserted (and flush is not). o_flush_cnt increments once per flush cycle. Both saturate at all-ones with no wrap. Counters are registered, so their value appears the cycle after the event.
- Reset asserted mid-stall returns to RUN immediately (asynchronous). The first cycle after release behaves as RUN.

Decomposition:
- Package hazard_pkg: state encoding (RUN=0, STALL=1) and forwarding select constants (FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01).
- One combinational sub-module, fwd_unit, instantiated once and producing both selects. The FSM and counters stay in hazard_ctrl.

Test Plan:
- Load-use on rs: idex_mem_read=1, idex_tar=5, id_src=5, LOAD_LAT=1 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle normal; stall_cnt=1.
- rt-only match with id_uses_rt=0 (id_tar=5, idex_tar=5) -> no stall. The same case with idex_tar=0 and id_src=0 -> no stall.
- LOAD_LAT=3 load-use -> exactly 3 stall cycles, then RUN; stall_cnt=3.
- Branch taken on stall cycle 2 of a LOAD_LAT=3 stall -> that cycle has flush=1, pc_write=1, both bubbles=1; next cycle normal; flush_cnt=1, stall_cnt=1.
- Forwarding: exmem_wr=3 (reg_write=1), memwb_wr=3 (reg_write=1), idex_src=3 -> fwd_a=10; clear exmem_reg_write -> fwd_a=01; exmem_wr=0 -> 01; both disabled -> 00.
- Counter saturation with CNT_W=2 under continuous stall -> stall_cnt holds 3. Reset pulse in STALL -> outputs forced low and counters 0; after release, normal control.
